// File: rtl/tdc_counter_if.sv
// rtl/tdc_counter_if.sv - measurement bus between a TDC driver and the tdc_counter core
interface tdc_counter_if #(
    parameter int DOUT_WIDTH = 10
);
    logic                         enable;
    logic                         ref_in;
    logic                         fb_in;
    logic signed [DOUT_WIDTH-1:0] d_out;
    logic                         d_valid;
    logic                         overflow;

    modport master (
        output enable, ref_in, fb_in,
        input  d_out, d_valid, overflow
    );

    modport slave (
        input  enable, ref_in, fb_in,
        output d_out, d_valid, overflow
    );
endinterface

// File: rtl/tdc_counter.sv
// rtl/tdc_counter.sv - counter-based TDC measuring signed ref_in/fb_in edge skew in clk periods
module tdc_counter #(
    parameter int DOUT_WIDTH = 10,
    parameter int OFFSET     = 0,
    parameter int MAX_CNT    = 511
) (
    input  logic        clk,
    input  logic        rst_n,
    tdc_counter_if.slave bus
);
    // Result arithmetic carries two guard bits so raw - OFFSET cannot wrap before clamping.
    localparam int AW = DOUT_WIDTH + 2;
    localparam logic signed [AW-1:0] MAX_CODE = AW'((1 << (DOUT_WIDTH - 1)) - 1);
    localparam logic signed [AW-1:0] OFF_S    = AW'(OFFSET);
    localparam logic [DOUT_WIDTH-1:0] CNT_LIM = DOUT_WIDTH'(MAX_CNT);

    typedef enum logic {IDLE, COUNT} state_t;

    logic [2:0]            r_ref_sync;
    logic [2:0]            r_fb_sync;
    state_t                r_state;
    logic                  r_lead_ref;
    logic [DOUT_WIDTH-1:0] r_cnt;
    logic signed [DOUT_WIDTH-1:0] r_d_out;
    logic                  r_d_valid;
    logic                  r_overflow;

    logic                  w_ref_rise;
    logic                  w_fb_rise;
    state_t                w_state_nxt;
    logic                  w_lead_nxt;
    logic [DOUT_WIDTH-1:0] w_cnt_nxt;
    logic                  w_emit;
    logic                  w_timeout;
    logic signed [AW-1:0]  w_raw;
    logic signed [AW-1:0]  w_diff;
    logic signed [AW-1:0]  w_code;
    logic                  w_ovf;

    // Both inputs see identical 2-FF sync + delay flop latency, so it cancels in the difference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_sync <= '0;
            r_fb_sync  <= '0;
        end else begin
            r_ref_sync <= {r_ref_sync[1:0], bus.ref_in};
            r_fb_sync  <= {r_fb_sync[1:0], bus.fb_in};
        end
    end

    assign w_ref_rise = r_ref_sync[1] & ~r_ref_sync[2];
    assign w_fb_rise  = r_fb_sync[1] & ~r_fb_sync[2];

    // FSM state, lead flag and interval counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_lead_ref <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lead_ref <= w_lead_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    // Next state: start on the first edge, stop on the lagging edge, timeout or disable.
    always_comb begin
        w_state_nxt = r_state;
        w_lead_nxt  = r_lead_ref;
        w_cnt_nxt   = r_cnt;
        w_emit      = 1'b0;
        w_timeout   = 1'b0;
        w_raw       = '0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (bus.enable) begin
                    if (w_ref_rise && w_fb_rise) begin
                        w_emit = 1'b1;
                    end else if (w_ref_rise) begin
                        w_lead_nxt  = 1'b1;
                        w_cnt_nxt   = DOUT_WIDTH'(1);
                        w_state_nxt = COUNT;
                    end else if (w_fb_rise) begin
                        w_lead_nxt  = 1'b0;
                        w_cnt_nxt   = DOUT_WIDTH'(1);
                        w_state_nxt = COUNT;
                    end
                end
            end
            COUNT: begin
                if (!bus.enable) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (r_lead_ref ? w_fb_rise : w_ref_rise) begin
                    w_emit      = 1'b1;
                    w_raw       = r_lead_ref ? AW'(r_cnt) : -AW'(r_cnt);
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LIM) begin
                    w_emit      = 1'b1;
                    w_timeout   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + DOUT_WIDTH'(1);
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Offset removal and symmetric clamp; a timeout reports full scale toward the leading side.
    always_comb begin
        w_diff = w_raw - OFF_S;
        w_code = w_diff;
        w_ovf  = 1'b0;
        if (w_timeout) begin
            w_code = r_lead_ref ? MAX_CODE : -MAX_CODE;
            w_ovf  = 1'b1;
        end else if (w_diff > MAX_CODE) begin
            w_code = MAX_CODE;
            w_ovf  = 1'b1;
        end else if (w_diff < -MAX_CODE) begin
            w_code = -MAX_CODE;
            w_ovf  = 1'b1;
        end
    end

    // Result register: one-cycle valid pulse, code and overflow held until the next result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_out    <= '0;
            r_d_valid  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_d_valid <= w_emit;
            if (w_emit) begin
                r_d_out    <= w_code[DOUT_WIDTH-1:0];
                r_overflow <= w_ovf;
            end
        end
    end

    assign bus.d_out    = r_d_out;
    assign bus.d_valid  = r_d_valid;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_tdc_counter.sv
// tb/tb_tdc_counter.sv - scoreboard bench for tdc_counter with OFFSET=0 and OFFSET=5 instances
module tb_tdc_counter;
    localparam int DW   = 10;
    localparam int MAXC = 511;
    localparam int MAXV = (1 << (DW - 1)) - 1;
    localparam int OFF1 = 5;

    typedef struct {
        int code;
        bit ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    logic enable;
    logic ref_in;
    logic fb_in;

    int   n_cmp;
    int   n_err;
    exp_t q0[$];
    exp_t q5[$];

    tdc_counter_if #(.DOUT_WIDTH(DW)) if0 ();
    tdc_counter_if #(.DOUT_WIDTH(DW)) if5 ();

    assign if0.enable = enable;
    assign if0.ref_in = ref_in;
    assign if0.fb_in  = fb_in;
    assign if5.enable = enable;
    assign if5.ref_in = ref_in;
    assign if5.fb_in  = fb_in;

    tdc_counter #(.DOUT_WIDTH(DW), .OFFSET(0), .MAX_CNT(MAXC)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    tdc_counter #(.DOUT_WIDTH(DW), .OFFSET(OFF1), .MAX_CNT(MAXC)) dut5 (
        .clk(clk), .rst_n(rst_n), .bus(if5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: skew d in clk periods (positive = fb late) to code and overflow.
    function automatic exp_t model(int d, int off);
        exp_t e;
        int   v;
        e.ovf = 1'b0;
        if (d > MAXC || d < -MAXC) begin
            e.code = (d > 0) ? MAXV : -MAXV;
            e.ovf  = 1'b1;
        end else begin
            v = d - off;
            if (v > MAXV) begin
                v = MAXV;
                e.ovf = 1'b1;
            end else if (v < -MAXV) begin
                v = -MAXV;
                e.ovf = 1'b1;
            end
            e.code = v;
        end
        return e;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_both(int d);
        q0.push_back(model(d, 0));
        q5.push_back(model(d, OFF1));
    endtask

    // One measurement: the lagging input rises |d| cycles after the leader; beyond MAXC it never rises.
    task automatic measure(int d);
        int ad;
        ad = (d < 0) ? -d : d;
        expect_both(d);
        if (d == 0) begin
            ref_in = 1'b1;
            fb_in  = 1'b1;
            cyc(10);
        end else begin
            if (d > 0) ref_in = 1'b1;
            else       fb_in  = 1'b1;
            if (ad <= MAXC) begin
                cyc(ad);
                if (d > 0) fb_in  = 1'b1;
                else       ref_in = 1'b1;
                cyc(10);
            end else begin
                cyc(MAXC + 12);
            end
        end
        ref_in = 1'b0;
        fb_in  = 1'b0;
        cyc(5);
    endtask

    // Monitors: every valid pulse must match the oldest expectation of its instance.
    always @(negedge clk) begin
        if (if0.d_valid) begin
            if (q0.size() == 0) begin
                chk("dut0 unexpected d_valid", 1, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("dut0 d_out", int'($signed(if0.d_out)), e.code);
                chk("dut0 overflow", int'(if0.overflow), int'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (if5.d_valid) begin
            if (q5.size() == 0) begin
                chk("dut5 unexpected d_valid", 1, 0);
            end else begin
                exp_t e;
                e = q5.pop_front();
                chk("dut5 d_out", int'($signed(if5.d_out)), e.code);
                chk("dut5 overflow", int'(if5.overflow), int'(e.ovf));
            end
        end
    end

    task automatic chk_reset_outputs(string tag);
        chk({tag, " dut0 d_out"}, int'($signed(if0.d_out)), 0);
        chk({tag, " dut0 d_valid"}, int'(if0.d_valid), 0);
        chk({tag, " dut0 overflow"}, int'(if0.overflow), 0);
        chk({tag, " dut5 d_out"}, int'($signed(if5.d_out)), 0);
        chk({tag, " dut5 d_valid"}, int'(if5.d_valid), 0);
        chk({tag, " dut5 overflow"}, int'(if5.overflow), 0);
    endtask

    initial begin
        int r;
        int d;
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        enable = 1'b0;
        ref_in = 1'b0;
        fb_in  = 1'b0;
        cyc(3);
        chk_reset_outputs("reset");
        rst_n  = 1'b1;
        cyc(2);
        enable = 1'b1;
        cyc(2);

        // Directed: ref leads, fb leads, simultaneous, range edges, timeouts.
        measure(37);
        measure(-20);
        measure(0);
        measure(511);
        measure(-511);
        measure(512);
        measure(-600);

        // Reset in the middle of a measurement: outputs clear at once, no late pulse.
        ref_in = 1'b1;
        cyc(20);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        cyc(1);
        ref_in = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(20);

        // Abort by enable low; an fb edge while disabled must not be remembered.
        ref_in = 1'b1;
        cyc(10);
        enable = 1'b0;
        cyc(3);
        fb_in = 1'b1;
        cyc(6);
        enable = 1'b1;
        cyc(3);
        ref_in = 1'b0;
        fb_in  = 1'b0;
        cyc(5);

        // Back-to-back: 3 then 8, second measurement starts on the first idle cycle.
        expect_both(3);
        expect_both(8);
        ref_in = 1'b1; cyc(1);
        ref_in = 1'b0; cyc(2);
        fb_in  = 1'b1; cyc(1);
        fb_in  = 1'b0;
        ref_in = 1'b1; cyc(1);
        ref_in = 1'b0; cyc(7);
        fb_in  = 1'b1; cyc(1);
        fb_in  = 1'b0;
        cyc(10);

        // Randomized skews, biased toward small values and the range boundary.
        for (int i = 0; i < 30; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) d = int'($urandom_range(0, 80)) - 40;
            else if (r < 9) d = int'($urandom_range(490, 530));
            else d = 540;
            if ($urandom_range(0, 1) == 1) d = -d;
            measure(d);
        end

        cyc(20);
        chk("dut0 pending results", q0.size(), 0);
        chk("dut5 pending results", q5.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
